// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// timer_arbiter
//   Round-robin scheduler sharing one prescaled countdown timer between
//   NUM_REQ requesters. A requester holds req_in high and gets one countdown
//   of duration_in ticks (one tick = TIMING_SCALE clocks). It must drop
//   req_in before it can be granted again.
//
// Ports
//   clk_in       : clock, all state on the rising edge
//   rst_n_in     : asynchronous active-low reset
//   req_in       : per-requester level request
//   duration_in  : packed per-requester durations in ticks, sampled at grant
//   abort_in     : cancels the active countdown (RUN only)
//   grant_out    : one-hot current owner, zero when idle
//   done_out     : one-cycle expiry pulse to the owner
//   busy_out     : timer is owned
//   count_out    : remaining ticks of the active countdown
// ---------------------------------------------------------------------------
module timer_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int TIMING_SCALE = 24,
   parameter int COUNT_WIDTH  = 8
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic [NUM_REQ-1:0]             req_in,
   input  logic [NUM_REQ*COUNT_WIDTH-1:0] duration_in,
   input  logic                           abort_in,
   output logic [NUM_REQ-1:0]             grant_out,
   output logic [NUM_REQ-1:0]             done_out,
   output logic                           busy_out,
   output logic [COUNT_WIDTH-1:0]         count_out
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int PS_W  = $clog2(TIMING_SCALE);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TIMING_SCALE - 1);
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [PS_W-1:0]        ps_q, ps_d;
   logic [COUNT_WIDTH-1:0] rem_q, rem_d;
   logic [NUM_REQ-1:0]     mask_q, mask_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic                   busy_q, busy_d;

   // Arbitration: first eligible requester searching upward from ptr+1.
   logic [NUM_REQ-1:0]     elig;
   logic [PTR_W-1:0]       idx;
   logic [PTR_W-1:0]       win;
   logic                   found;
   logic [NUM_REQ-1:0]     win_oh;
   logic [COUNT_WIDTH-1:0] win_dur;

   always_comb begin
      elig  = req_in & ~mask_q;
      found = 1'b0;
      win   = ptr_q;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         win_oh[i] = (PTR_W'(i) == win);
      end
      win_dur = duration_in[win*COUNT_WIDTH +: COUNT_WIDTH];
   end

   // Next-state and registered-output logic
   logic [NUM_REQ-1:0] mask_set;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ps_d     = ps_q;
      rem_d    = rem_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      done_d   = '0;
      mask_set = '0;

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               ptr_d   = win;
               rem_d   = win_dur;
               grant_d = win_oh;
               busy_d  = 1'b1;
               ps_d    = '0;
               if (win_dur == '0) begin
                  // Zero-length request expires straight away.
                  state_d = S_DONE;
                  done_d  = win_oh;
               end else begin
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            // Cancel outranks a final tick in the same cycle.
            if (!req_in[ptr_q] || abort_in) begin
               state_d         = S_IDLE;
               rem_d           = '0;
               ps_d            = '0;
               grant_d         = '0;
               busy_d          = 1'b0;
               mask_set[ptr_q] = 1'b1;
            end else if (ps_q == PS_LAST) begin
               ps_d  = '0;
               rem_d = rem_q - 1'b1;
               if (rem_q == COUNT_WIDTH'(1)) begin
                  state_d       = S_DONE;
                  done_d[ptr_q] = 1'b1;
               end
            end else begin
               ps_d = ps_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d         = S_IDLE;
            grant_d         = '0;
            busy_d          = 1'b0;
            mask_set[ptr_q] = 1'b1;
         end

         default: state_d = S_IDLE;
      endcase

      // Clear is applied after set so a request dropped in the same cycle
      // is not left locked out.
      mask_d = (mask_q | mask_set) & req_in;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         ptr_q   <= PTR_RST;
         ps_q    <= '0;
         rem_q   <= '0;
         mask_q  <= '0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ps_q    <= ps_d;
         rem_q   <= rem_d;
         mask_q  <= mask_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign grant_out = grant_q;
   assign done_out  = done_q;
   assign busy_out  = busy_q;
   assign count_out = rem_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timer_arbiter
//   Scenario tasks plus a randomized run, checked against a reference model
//   that tracks each grant as (owner, duration, cycles since grant).
// ---------------------------------------------------------------------------
module tb_timer_arbiter;

   localparam int N  = 4;
   localparam int TS = 4;
   localparam int CW = 8;
   localparam int OW = 2*N + 1 + CW;

   logic            clk_in   = 1'b0;
   logic            rst_n_in = 1'b0;
   logic [N-1:0]    req_r    = '0;
   logic [N*CW-1:0] dur_r    = '0;
   logic            abort_r  = 1'b0;
   logic [N-1:0]    grant_out;
   logic [N-1:0]    done_out;
   logic            busy_out;
   logic [CW-1:0]   count_out;

   int n_tests = 0;
   int n_fail  = 0;

   timer_arbiter #(.NUM_REQ(N), .TIMING_SCALE(TS), .COUNT_WIDTH(CW)) dut (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .req_in      (req_r),
      .duration_in (dur_r),
      .abort_in    (abort_r),
      .grant_out   (grant_out),
      .done_out    (done_out),
      .busy_out    (busy_out),
      .count_out   (count_out)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- reference model ----------------
   int           m_owner;  // -1 when idle
   int           m_t;      // cycles since grant, 1 in the first granted cycle
   int           m_end;    // cycle (relative) carrying the done pulse
   int           m_d;      // latched duration
   int           m_last;   // last granted requester
   logic [N-1:0] m_mask;   // already served, waiting for req to drop

   function automatic void model_reset();
      m_owner = -1; m_t = 0; m_end = 0; m_d = 0; m_last = N-1; m_mask = '0;
   endfunction

   function automatic void model_step();
      logic [N-1:0] set;
      set = '0;
      if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (m_owner < 0 && req_r[i] && !m_mask[i]) m_owner = i;
         end
         if (m_owner >= 0) begin
            m_last = m_owner;
            m_d    = int'(dur_r[m_owner*CW +: CW]);
            m_t    = 1;
            m_end  = (m_d == 0) ? 1 : m_d*TS + 1;
         end
      end else if (m_t == m_end) begin
         set[m_owner] = 1'b1;
         m_owner = -1;
      end else if (!req_r[m_owner] || abort_r) begin
         set[m_owner] = 1'b1;
         m_owner = -1;
      end else begin
         m_t++;
      end
      m_mask = (m_mask | set) & req_r;
   endfunction

   function automatic logic [OW-1:0] exp_vec();
      logic [N-1:0]  g;
      logic [N-1:0]  d;
      logic [CW-1:0] c;
      if (m_owner < 0) return '0;
      g = '0;
      g[m_owner] = 1'b1;
      d = (m_t == m_end) ? g : '0;
      c = (m_t >= m_end) ? '0 : CW'(m_d - (m_t - 1) / TS);
      return {g, d, 1'b1, c};
   endfunction

   function automatic logic [OW-1:0] obs_vec();
      return {grant_out, done_out, busy_out, count_out};
   endfunction

   function automatic int idx_of(logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   // One clock: inputs already driven, model follows the same edge.
   task automatic tick();
      @(posedge clk_in);
      model_step();
      #1;
   endtask

   task automatic settle();
      req_r = '0; abort_r = 1'b0;
      repeat (3) tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk_in);
      #1;
      n_tests++;
      if (obs_vec() !== '0) begin
         n_fail++; $display("FAIL reset_state got=%h want=%h", obs_vec(), {OW{1'b0}});
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      model_reset();
   endtask

   task automatic test_round_robin();
      int q[$];
      logic [N-1:0] prev;
      prev = '0;
      req_r = '1;
      for (int i = 0; i < N; i++) dur_r[i*CW +: CW] = 8'd1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rr cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
         if (grant_out != '0 && grant_out != prev) q.push_back(idx_of(grant_out));
         prev = grant_out;
      end
      n_tests++;
      if (q.size() != N) begin
         n_fail++; $display("FAIL rr_count got=%0d want=%0d", q.size(), N);
      end
      for (int i = 0; i < q.size() && i < N; i++) begin
         n_tests++;
         if (q[i] != i) begin
            n_fail++; $display("FAIL rr_order slot=%0d got=%0d want=%0d", i, q[i], i);
         end
      end
      // Drop and re-raise: service resumes with requester 0.
      req_r = '0; tick();
      req_r = '1; tick();
      n_tests++;
      if (grant_out !== 4'b0001 || obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL rr_regrant got=%b want=%b", grant_out, 4'b0001);
      end
      settle();
   endtask

   task automatic test_single();
      req_r = 4'b0100;
      dur_r[2*CW +: CW] = 8'd3;
      for (int k = 1; k <= 16; k++) begin
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL single cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
         if (k == 1) begin
            n_tests++;
            if (grant_out !== 4'b0100 || count_out !== 8'd3) begin
               n_fail++; $display("FAIL single_grant got=%b/%0d want=0100/3", grant_out, count_out);
            end
         end
         if (k == 13) begin
            n_tests++;
            if (done_out !== 4'b0100) begin
               n_fail++; $display("FAIL single_done got=%b want=0100", done_out);
            end
         end
         if (k == 14) begin
            n_tests++;
            if (busy_out !== 1'b0) begin
               n_fail++; $display("FAIL single_busy_drop got=%b want=0", busy_out);
            end
         end
      end
      settle();
   endtask

   task automatic test_zero_duration();
      req_r = 4'b0010;
      dur_r[1*CW +: CW] = 8'd0;
      tick();
      n_tests++;
      if (done_out !== 4'b0010 || obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL zero_done got=%b want=0010", done_out);
      end
      dur_r[1*CW +: CW] = 8'd5;
      for (int k = 2; k <= 12; k++) begin
         tick();
         n_tests++;
         if (grant_out !== '0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL zero_no_regrant cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      settle();
   endtask

   task automatic test_cancel_race();
      req_r = 4'b0001;
      dur_r[0 +: CW] = 8'd2;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL race cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      // Cycle 8 carries the final tick; request drops in the same cycle.
      req_r = '0;
      tick();
      n_tests++;
      if (obs_vec() !== '0 || obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL race_cancel got=%h want=%h", obs_vec(), {OW{1'b0}});
      end
      settle();
   endtask

   task automatic test_abort();
      req_r = 4'b1010;
      dur_r[1*CW +: CW] = 8'd10;
      dur_r[3*CW +: CW] = 8'd2;
      for (int k = 1; k <= 15; k++) begin
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL abort_run cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      abort_r = 1'b1;
      tick();
      abort_r = 1'b0;
      n_tests++;
      if (grant_out !== '0 || done_out !== '0 || obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL abort_idle got=%h want=%h", obs_vec(), exp_vec());
      end
      tick();
      n_tests++;
      if (grant_out !== 4'b1000 || obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL abort_next_grant got=%b want=1000", grant_out);
      end
      for (int k = 0; k < 14; k++) begin
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL abort_tail step=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      settle();
   endtask

   task automatic test_reset_mid_run();
      req_r = 4'b0001;
      dur_r[0 +: CW] = 8'd4;
      for (int k = 1; k <= 6; k++) tick();
      rst_n_in = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (obs_vec() !== '0) begin
         n_fail++; $display("FAIL reset_mid got=%h want=%h", obs_vec(), {OW{1'b0}});
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
      n_tests++;
      if (grant_out !== 4'b0001 || count_out !== 8'd4 || obs_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_regrant got=%b/%0d want=0001/4", grant_out, count_out);
      end
      for (int k = 2; k <= 20; k++) begin
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_after cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      settle();
   endtask

   task automatic test_random();
      for (int k = 0; k < 2000; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) req_r[i] = ~req_r[i];
         end
         abort_r = ($urandom_range(31) == 0);
         dur_r[$urandom_range(N-1)*CW +: CW] = CW'($urandom_range(3));
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      settle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_single();
      test_zero_duration();
      test_cancel_race();
      test_abort();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares one prescaled countdown timer between `NUM_REQ` requesters. Each requester asks for a delay of N timebase ticks, where one tick is `TIMING_SCALE` clocks. The arbiter grants the timer to one requester at a time, runs the countdown and pulses that requester's done line on expiry. It sits between the LED/display sequencing logic and the shared timing datapath, so each sequencer no longer needs its own prescaled counter.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMING_SCALE`, 24, clocks per timebase tick (≥2)
- `COUNT_WIDTH`, 8, width of one duration field
- `clk_in` input 1: single clock, all state on rising edge
- `rst_n_in` input 1: reset, asynchronous, active-low
- `req_in` input NUM_REQ: per-requester level request
- `duration_in` input NUM_REQ*COUNT_WIDTH: requester i's duration in bits [i*COUNT_WIDTH +: COUNT_WIDTH], in ticks
- `abort_in` input 1: cancels the active countdown
- `grant_out` output NUM_REQ: one-hot owner of the timer, all-zero when idle
- `done_out` output NUM_REQ: one-cycle expiry pulse to the owner
- `busy_out` output 1: high while the timer is owned
- `count_out` output COUNT_WIDTH: remaining ticks of the active countdown

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- **Eligibility:** requester i is eligible when `req_in[i]` is 1 and `release_mask[i]` is 0.
- **IDLE:**
  - If any requester is eligible, pick the first one searching from `ptr+1` upward, wrapping modulo NUM_REQ.
  - On that pick: set `ptr` to the winner; latch its duration into `remaining`; set `grant_out`, `busy_out`; clear `prescale` to 0.
  - Next state is DONE if the duration is 0, otherwise RUN.
- **RUN:**
  - `prescale` counts 0..TIMING_SCALE-1 and wraps. A tick is the cycle where `prescale` equals TIMING_SCALE-1.
  - On each tick, `remaining` decrements.
  - A tick with `remaining` equal to 1 moves to DONE, with `remaining` becoming 0.
- **DONE (one cycle):**
  - `done_out[ptr]`=1, `grant_out` still held.
  - Set `release_mask[ptr]`. Next state IDLE, with `grant_out`, `busy_out` and `done_out` cleared.
- **Release mask:** `release_mask[i]` clears on any cycle where `req_in[i]` is 0. A requester therefore gets exactly one countdown per rising level of `req_in` and must drop `req_in` to request again.
- **Cancel:** in RUN, `req_in[owner]`=0 or `abort_in`=1 moves straight to IDLE.
  - No done pulse is issued, `remaining` clears to 0 and `ptr` is kept.
  - After an abort, the owner's `release_mask` bit is set. It needs a fresh request.
- **Duration sampling:** `duration_in` is sampled only at grant. Later changes are ignored.
- **Priority:** cancel or abort beats a final tick in the same cycle, so no done pulse is issued. `abort_in` has no effect in IDLE or DONE.
- **Width rules:** `count_out` mirrors `remaining`. The `prescale` width is clog2(TIMING_SCALE). Decrement never underflows, because RUN is never entered with `remaining`=0.

## Timing
- **Reset values, applied asynchronously and immediately, including mid-countdown:**
  - outputs: `grant_out`=0, `done_out`=0, `busy_out`=0, `count_out`=0
  - internal state: state=IDLE, `ptr`=NUM_REQ-1 so requester 0 is first, `prescale`=0, `release_mask`=0
  - No done pulse is issued for an interrupted countdown.
- Arbitration uses `req_in` as seen in cycle 0 (IDLE). `grant_out` and `busy_out` are high from cycle 1.
- For duration D≥1, `done_out` is high in cycle D*TIMING_SCALE+1. For D=0 it is high in cycle 1.
- `grant_out` drops in the cycle after done. The earliest next grant is the cycle after that, giving 2 cycles of IDLE/re-arbitration overhead.
- A requester whose request arrives while the timer is busy waits. There is no queue depth beyond one pending level per requester.

## Test plan
All scenarios use TIMING_SCALE=4, NUM_REQ=4, COUNT_WIDTH=8.
- **Single request:** `req_in[2]`=1, D=3 at cycle 0 → `grant_out`=4'b0100 from cycle 1; `count_out` steps 3,2,1,0; `done_out[2]` pulses only in cycle 13; `busy_out` low in cycle 14.
- **Round-robin:** `req_in`=4'b1111 held, all D=1 → grants in order 0,1,2,3, one each; after that no further grants until each `req_in` bit is dropped and re-raised.
- **Zero duration:** `req_in[1]`=1, D=0 → `done_out[1]` in cycle 1; D=5 applied later while `req_in[1]` is still held → no regrant.
- **Cancel race:** `req_in[0]` dropped in the same cycle as the final tick → no done pulse; IDLE next cycle; `count_out`=0.
- **Abort:** `abort_in` pulsed in mid-RUN with D=10 → IDLE next cycle, no done; requester 3 pending → granted 1 cycle later.
- **Reset mid-run:** `rst_n_in` low at cycle 6 of a D=4 countdown → all outputs 0 immediately; after release, the still-high request from requester 0 is granted 1 cycle after the first IDLE cycle, with the full duration reloaded.
